mario_tile_poller: RTL and testbench
====================================

# mario_tile_poller

Collision responder for the Mario movement controller: once per frame it samples Mario's screen position, converts four probe points to tile-map addresses, reads the level tile map, and returns the tile codes on `mario_poll_up/down/left/right`. It also owns the horizontal scroll offset: it advances on the controller's `Shift` pulse, and is exported to the background renderer.

## Interface
- `TILE`, 20: tile edge in pixels.
- `MAP_COLS`, 256: tile-map width in tiles.
- `MAP_ROWS`, 20: tile-map height in tiles.
- `ADDR_W`, 13: map address width.
- `X_MIN`, 120 / `Y_MIN`, 40 / `Y_MAX`, 439: playfield bounds in screen pixels.
- `VIEW_W`, 400: playfield width in pixels.
- `HALF`, 20: Mario half-size.
- `PROBE_GAP`, 2: probe distance beyond Mario's edge.
- `SHIFT_PX`, 40: scroll advance per `Shift`.
- `BOUND_CODE`, 3'b111: code returned for off-map probes.
- `Clk`  in  1  system clock.
- `Reset`  in  1  synchronous, active-high.
- `frame_clk`  in  1  vertical-sync frame clock.
- `Mario_X_Pos`, `Mario_Y_Pos`  in  10  Mario centre, screen pixels.
- `Shift`  in  1  single-cycle scroll request.
- `map_addr`  out  ADDR_W  tile-map read address, computed as row*MAP_COLS+col.
- `map_rd`  out  1  read strobe.
- `map_rdata`  in  3  tile code, valid one cycle after the `map_rd` cycle.
- `mario_poll_up`, `mario_poll_down`, `mario_poll_left`, `mario_poll_right`  out  3  each, the latest tile codes.
- `scroll_px`  out  13  world x of the playfield's left edge.
- `poll_valid`  out  1  one-cycle pulse when the poll outputs update.

## Operation
- Edge detect: `frame_clk` is registered twice. `edge` is asserted for one cycle when the current sample is 1 and the previous sample is 0. Cycle E is defined as the cycle in which `edge` is high.
- Scroll update: `Shift` high in any cycle sets `scroll_px` = min(`scroll_px` + `SHIFT_PX`, `MAP_COLS`*`TILE` − `VIEW_W`).
  - With default parameters the maximum is 4720.
  - Saturation holds at the maximum; there is no wrap-around.
- FSM states: IDLE → LATCH → ADDR0 → CAP0 → ADDR1 → CAP1 → ADDR2 → CAP2 → ADDR3 → CAP3 → IDLE.
- IDLE: waits for `edge`.
- LATCH: registers `Mario_X_Pos`, `Mario_Y_Pos` and `scroll_px`.
- Probe order and points (screen coordinates: X = latched x, Y = latched y):
  - Probe 0, up: (X, Y − HALF − GAP).
  - Probe 1, down: (X, Y + HALF − 1 + GAP).
  - Probe 2, left: (X − HALF − GAP, Y).
  - Probe 3, right: (X + HALF − 1 + GAP, Y).
- Address arithmetic, all signed 14-bit:
  - wx = sx − X_MIN + scroll; wy = sy − Y_MIN.
  - col = floor(wx/TILE); row = floor(wy/TILE).
  - Results must be bit-exact floors. The division method is free.
- Out-of-range rule: a probe is off-map when wx < 0, col ≥ MAP_COLS, wy < 0, sy > Y_MAX, or row ≥ MAP_ROWS.
- ADDRk:
  - On-map probe: drive `map_addr` and set `map_rd` = 1.
  - Off-map probe: `map_rd` = 0 and `map_addr` is held.
- CAPk: store `map_rdata`, or `BOUND_CODE` if the probe was off-map, into shadow register k.
- CAP3 exit: all four poll outputs load from the shadow registers simultaneously. `poll_valid` pulses.
- Hold behaviour: poll outputs are stable between updates and never show a partial sweep.
- `edge` during a sweep (non-IDLE state) is ignored. The sweep completes unchanged.
- `Shift` during a sweep updates `scroll_px` immediately but does not affect the latched scroll.
- Reset values: all polls 0; `scroll_px` 0; `map_rd` 0; `map_addr` 0; `poll_valid` 0; FSM IDLE; shadow registers 0.
- Reset mid-sweep: the sweep is aborted with no `poll_valid` pulse.

## Timing
- E+1: LATCH. The latch captures Mario positions updated at the end of E and `scroll_px` including any `Shift` from cycle E.
- Probe k: ADDRk in cycle E+2+2k; CAPk in cycle E+3+2k.
- E+10: new poll values are visible and `poll_valid` = 1. Fixed latency is 10 cycles from `edge`, independent of off-map probes.
- `map_rd` is high for at most 4 cycles per frame, never in consecutive cycles.
- `scroll_px` changes one cycle after `Shift`.

## Test plan
- Map read: X=300, Y=200, scroll 0, `frame_clk` rises.
  - Required reads: `map_addr` 1545, 2313, 2055, 2058 in cycles E+2, E+4, E+6, E+8.
  - Map contents 1,2,0,3 at those addresses → up=1, down=2, left=0, right=3 and `poll_valid` in cycle E+10.
- Scroll effect: one `Shift` pulse in cycle E, same position → `scroll_px` = 40 and the right probe address = 2060.
- Saturation: 119 `Shift` pulses → `scroll_px` = 4720 after the 118th and stays 4720 after the 119th.
- Off-map probes: X=140, Y=419, scroll 0 → left and down return 3'b111 with `map_rd` low in E+4 and E+6; up and right read the map.
- Hold and ignore: outputs are unchanged between frames; a second `frame_clk` edge at E+5 is ignored and `poll_valid` pulses once.
- Reset mid-sweep: `Reset` in E+5 → polls 0, `scroll_px` 0, no `poll_valid`; the next `edge` runs a full sweep.

Source files
------------

// File: rtl/mario_tile_poller_if.sv
// Tile-map read port shared by the collision poller (master) and the level map (slave).
// The map answers map_rdata one cycle after a map_rd cycle.
interface mario_tile_poller_if #(
    parameter int unsigned ADDR_W = 13
) ();
    logic [ADDR_W-1:0] map_addr;
    logic              map_rd;
    logic [2:0]        map_rdata;

    modport master (
        output map_addr,
        output map_rd,
        input  map_rdata
    );

    modport slave (
        input  map_addr,
        input  map_rd,
        output map_rdata
    );
endinterface

// File: rtl/mario_tile_poller.sv
// Once per frame, probes four points around Mario against the level tile map and
// publishes the tile codes together; also owns the saturating horizontal scroll offset.
module mario_tile_poller #(
    parameter int unsigned TILE       = 20,
    parameter int unsigned MAP_COLS   = 256,
    parameter int unsigned MAP_ROWS   = 20,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned X_MIN      = 120,
    parameter int unsigned Y_MIN      = 40,
    parameter int unsigned Y_MAX      = 439,
    parameter int unsigned VIEW_W     = 400,
    parameter int unsigned HALF       = 20,
    parameter int unsigned PROBE_GAP  = 2,
    parameter int unsigned SHIFT_PX   = 40,
    parameter logic [2:0]  BOUND_CODE = 3'b111
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      frame_clk,
    input  logic [9:0]                Mario_X_Pos,
    input  logic [9:0]                Mario_Y_Pos,
    input  logic                      Shift,
    mario_tile_poller_if.master       map_bus,
    output logic [2:0]                mario_poll_up,
    output logic [2:0]                mario_poll_down,
    output logic [2:0]                mario_poll_left,
    output logic [2:0]                mario_poll_right,
    output logic [12:0]               scroll_px,
    output logic                      poll_valid
);

    localparam logic [13:0]        ScrollMax = 14'(MAP_COLS * TILE - VIEW_W);
    localparam logic [13:0]        ShiftStep = 14'(SHIFT_PX);
    localparam logic signed [13:0] NearOff   = 14'(HALF + PROBE_GAP);
    localparam logic signed [13:0] FarOff    = 14'(HALF - 1 + PROBE_GAP);
    localparam logic signed [13:0] XMinS     = 14'(X_MIN);
    localparam logic signed [13:0] YMinS     = 14'(Y_MIN);
    localparam logic signed [13:0] YMaxS     = 14'(Y_MAX);
    localparam logic [13:0]        ColsW     = 14'(MAP_COLS);
    localparam logic [13:0]        RowsW     = 14'(MAP_ROWS);

    typedef enum logic [3:0] {
        StIdle,
        StLatch,
        StAddr0,
        StCap0,
        StAddr1,
        StCap1,
        StAddr2,
        StCap2,
        StAddr3,
        StCap3
    } state_e;

    state_e state_q, state_d;

    logic              fc_q1, fc_q2;
    logic              frame_edge;
    logic [9:0]        x_q, y_q;
    logic [12:0]       scroll_lat_q;
    logic [12:0]       scroll_d;
    logic [13:0]       scroll_sum;
    logic [3:0][2:0]   shadow_q;
    logic [ADDR_W-1:0] addr_q;
    logic              poll_valid_q;
    logic [2:0]        up_q, down_q, left_q, right_q;

    logic              is_addr, is_cap;
    logic [1:0]        probe_idx;
    logic signed [13:0] sx, sy, wx, wy;
    logic [13:0]       col_w, row_w;
    logic              off_map;
    logic [ADDR_W-1:0] probe_addr;
    logic [2:0]        cap_code;

    assign frame_edge = fc_q1 & ~fc_q2;

    always_comb begin
        scroll_sum = {1'b0, scroll_px} + ShiftStep;
        scroll_d   = scroll_px;
        if (Shift) begin
            scroll_d = (scroll_sum > ScrollMax) ? ScrollMax[12:0] : scroll_sum[12:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        is_addr   = 1'b0;
        is_cap    = 1'b0;
        probe_idx = 2'd0;
        unique case (state_q)
            StIdle:  if (frame_edge) state_d = StLatch;
            StLatch: state_d = StAddr0;
            StAddr0: begin state_d = StCap0;  is_addr = 1'b1; probe_idx = 2'd0; end
            StCap0:  begin state_d = StAddr1; is_cap  = 1'b1; probe_idx = 2'd0; end
            StAddr1: begin state_d = StCap1;  is_addr = 1'b1; probe_idx = 2'd1; end
            StCap1:  begin state_d = StAddr2; is_cap  = 1'b1; probe_idx = 2'd1; end
            StAddr2: begin state_d = StCap2;  is_addr = 1'b1; probe_idx = 2'd2; end
            StCap2:  begin state_d = StAddr3; is_cap  = 1'b1; probe_idx = 2'd2; end
            StAddr3: begin state_d = StCap3;  is_addr = 1'b1; probe_idx = 2'd3; end
            StCap3:  begin state_d = StIdle;  is_cap  = 1'b1; probe_idx = 2'd3; end
            default: state_d = StIdle;
        endcase
    end

    // Probe geometry is recomputed from the latched frame values in both ADDRk and CAPk,
    // so the off-map decision needs no extra storage between the two cycles.
    always_comb begin
        sx = 14'(x_q);
        sy = 14'(y_q);
        unique case (probe_idx)
            2'd0: sy = 14'(y_q) - NearOff;
            2'd1: sy = 14'(y_q) + FarOff;
            2'd2: sx = 14'(x_q) - NearOff;
            2'd3: sx = 14'(x_q) + FarOff;
            default: ;
        endcase
        wx = sx - XMinS + 14'(scroll_lat_q);
        wy = sy - YMinS;
        // Negative wx/wy are off-map anyway, so an unsigned divide gives the floor where it matters.
        col_w = 14'($unsigned(wx) / TILE);
        row_w = 14'($unsigned(wy) / TILE);
        off_map = wx[13] | wy[13] | (sy > YMaxS) | (col_w >= ColsW) | (row_w >= RowsW);
        probe_addr = ADDR_W'(row_w * MAP_COLS + col_w);
    end

    assign map_bus.map_rd   = is_addr & ~off_map;
    assign map_bus.map_addr = map_bus.map_rd ? probe_addr : addr_q;
    assign cap_code         = off_map ? BOUND_CODE : map_bus.map_rdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            fc_q1        <= 1'b0;
            fc_q2        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            scroll_lat_q <= '0;
            scroll_px    <= '0;
            shadow_q     <= '0;
            addr_q       <= '0;
            poll_valid_q <= 1'b0;
            up_q         <= '0;
            down_q       <= '0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            state_q      <= state_d;
            fc_q1        <= frame_clk;
            fc_q2        <= fc_q1;
            scroll_px    <= scroll_d;
            addr_q       <= map_bus.map_addr;
            poll_valid_q <= (state_q == StCap3);
            if (state_q == StLatch) begin
                x_q          <= Mario_X_Pos;
                y_q          <= Mario_Y_Pos;
                scroll_lat_q <= scroll_px;
            end
            if (is_cap) begin
                shadow_q[probe_idx] <= cap_code;
            end
            // All four outputs move together; the right probe is taken straight from the bus.
            if (state_q == StCap3) begin
                up_q    <= shadow_q[0];
                down_q  <= shadow_q[1];
                left_q  <= shadow_q[2];
                right_q <= cap_code;
            end
        end
    end

    assign mario_poll_up    = up_q;
    assign mario_poll_down  = down_q;
    assign mario_poll_left  = left_q;
    assign mario_poll_right = right_q;
    assign poll_valid       = poll_valid_q;

endmodule

// File: tb/tb_mario_tile_poller.sv
// Randomised bench for mario_tile_poller against a pixel/tile arithmetic reference model.
module tb_mario_tile_poller;

    localparam int TILE = 20, MAP_COLS = 256, MAP_ROWS = 20;
    localparam int X_MIN = 120, Y_MIN = 40, Y_MAX = 439;
    localparam int HALF = 20, GAP = 2, SHIFT_PX = 40;
    localparam int SCROLL_MAX = MAP_COLS * TILE - 400;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        Shift = 1'b0;
    logic [9:0]  Mario_X_Pos = '0;
    logic [9:0]  Mario_Y_Pos = '0;
    logic [2:0]  mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right;
    logic [12:0] scroll_px;
    logic        poll_valid;

    mario_tile_poller_if #(.ADDR_W(13)) map_bus ();

    mario_tile_poller dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .frame_clk        (frame_clk),
        .Mario_X_Pos      (Mario_X_Pos),
        .Mario_Y_Pos      (Mario_Y_Pos),
        .Shift            (Shift),
        .map_bus          (map_bus.master),
        .mario_poll_up    (mario_poll_up),
        .mario_poll_down  (mario_poll_down),
        .mario_poll_left  (mario_poll_left),
        .mario_poll_right (mario_poll_right),
        .scroll_px        (scroll_px),
        .poll_valid       (poll_valid)
    );

    always #5 Clk = ~Clk;

    logic [2:0] mem [0:8191];
    always @(posedge Clk) if (map_bus.map_rd) map_bus.map_rdata <= mem[map_bus.map_addr];

    int n_vec = 0, n_err = 0;
    int scroll_m = 0, lat_scroll = 0;
    int m_last_addr = 0;
    logic [2:0] m_poll [4];
    bit   exp_off [4];
    int   exp_addr [4];
    logic [2:0] exp_code [4];

    logic        obs_rd [0:20];
    logic [12:0] obs_addr [0:20];
    logic        obs_pv [0:20];
    logic [12:0] obs_scroll [0:20];
    logic [2:0]  obs_poll [0:20][4];

    function automatic int floor_div(input int a, input int b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    task automatic model_probe(input int x, input int y, input int s, input int k,
                               output bit off, output int addr);
        int sx = x, sy = y, wx, wy, col, row;
        case (k)
            0: sy = y - HALF - GAP;
            1: sy = y + HALF - 1 + GAP;
            2: sx = x - HALF - GAP;
            default: sx = x + HALF - 1 + GAP;
        endcase
        wx = sx - X_MIN + s;
        wy = sy - Y_MIN;
        col = floor_div(wx, TILE);
        row = floor_div(wy, TILE);
        off = (wx < 0) || (col >= MAP_COLS) || (wy < 0) || (sy > Y_MAX) || (row >= MAP_ROWS);
        addr = row * MAP_COLS + col;
    endtask

    task automatic compute_expect(input int x, input int y, input int s);
        for (int k = 0; k < 4; k++) begin
            model_probe(x, y, s, k, exp_off[k], exp_addr[k]);
            exp_code[k] = exp_off[k] ? 3'b111 : mem[exp_addr[k]];
        end
    endtask

    task automatic model_advance(input bit aborted);
        if (aborted) begin
            m_last_addr = 0;
            for (int k = 0; k < 4; k++) m_poll[k] = 3'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!exp_off[k]) m_last_addr = exp_addr[k];
                m_poll[k] = exp_code[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic record(input int c);
        obs_rd[c]      = map_bus.map_rd;
        obs_addr[c]    = map_bus.map_addr;
        obs_pv[c]      = poll_valid;
        obs_scroll[c]  = scroll_px;
        obs_poll[c][0] = mario_poll_up;
        obs_poll[c][1] = mario_poll_down;
        obs_poll[c][2] = mario_poll_left;
        obs_poll[c][3] = mario_poll_right;
    endtask

    task automatic apply_reset();
        Reset = 1'b1; Shift = 1'b0; frame_clk = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        scroll_m = 0; m_last_addr = 0;
        for (int k = 0; k < 4; k++) m_poll[k] = 3'd0;
        tick();
    endtask

    // Observation index c is cycle E+c; the frame_clk rise is timed so the edge lands at c=0.
    task automatic sweep(input int x, input int y, input bit shift_e, input bit second_edge,
                         input int rst_at);
        Mario_X_Pos = 10'(x); Mario_Y_Pos = 10'(y); frame_clk = 1'b1;
        tick();
        Shift = shift_e;
        record(0);
        if (shift_e) scroll_m = (scroll_m + SHIFT_PX > SCROLL_MAX) ? SCROLL_MAX : scroll_m + SHIFT_PX;
        lat_scroll = scroll_m;
        for (int c = 1; c <= 20; c++) begin
            tick();
            Shift = 1'b0;
            record(c);
            if (c == 1) frame_clk = 1'b0;
            if (second_edge && c == 4) frame_clk = 1'b1;
            if (c == 6) frame_clk = 1'b0;
            Reset = (c == rst_at);
        end
        Reset = 1'b0;
        if (rst_at > 0) scroll_m = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++; if (mario_poll_up !== 3'd0) begin n_err++; $display("FAIL reset_up got %0d want 0", mario_poll_up); end
        n_vec++; if (mario_poll_down !== 3'd0) begin n_err++; $display("FAIL reset_down got %0d want 0", mario_poll_down); end
        n_vec++; if (mario_poll_left !== 3'd0) begin n_err++; $display("FAIL reset_left got %0d want 0", mario_poll_left); end
        n_vec++; if (mario_poll_right !== 3'd0) begin n_err++; $display("FAIL reset_right got %0d want 0", mario_poll_right); end
        n_vec++; if (scroll_px !== 13'd0) begin n_err++; $display("FAIL reset_scroll got %0d want 0", scroll_px); end
        n_vec++; if (map_bus.map_rd !== 1'b0 || map_bus.map_addr !== 13'd0 || poll_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_bus rd=%b addr=%0d pv=%b want 0 0 0", map_bus.map_rd, map_bus.map_addr, poll_valid);
        end
    endtask

    task automatic test_map_read();
        int want_addr [4] = '{1545, 2313, 2055, 2058};
        logic [2:0] want_code [4] = '{3'd1, 3'd2, 3'd0, 3'd3};
        apply_reset();
        for (int k = 0; k < 4; k++) mem[want_addr[k]] = want_code[k];
        sweep(300, 200, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (obs_rd[2 + 2 * k] !== 1'b1 || obs_addr[2 + 2 * k] !== 13'(want_addr[k])) begin
                n_err++; $display("FAIL map_read_addr%0d rd=%b addr=%0d want rd=1 addr=%0d", k, obs_rd[2 + 2 * k], obs_addr[2 + 2 * k], want_addr[k]);
            end
            n_vec++;
            if (obs_poll[10][k] !== want_code[k]) begin
                n_err++; $display("FAIL map_read_poll%0d got %0d want %0d", k, obs_poll[10][k], want_code[k]);
            end
        end
        n_vec++;
        if (obs_pv[9] !== 1'b0 || obs_pv[10] !== 1'b1 || obs_pv[11] !== 1'b0) begin
            n_err++; $display("FAIL map_read_valid pv9..11=%b%b%b want 010", obs_pv[9], obs_pv[10], obs_pv[11]);
        end
        compute_expect(300, 200, 0);
        model_advance(1'b0);
    endtask

    task automatic test_scroll();
        apply_reset();
        sweep(300, 200, 1'b1, 1'b0, 0);
        n_vec++; if (obs_scroll[0] !== 13'd0) begin n_err++; $display("FAIL scroll_same_cycle got %0d want 0", obs_scroll[0]); end
        n_vec++; if (obs_scroll[1] !== 13'd40) begin n_err++; $display("FAIL scroll_after got %0d want 40", obs_scroll[1]); end
        n_vec++; if (obs_rd[8] !== 1'b1 || obs_addr[8] !== 13'd2060) begin
            n_err++; $display("FAIL scroll_right_addr rd=%b addr=%0d want 1 2060", obs_rd[8], obs_addr[8]);
        end
        compute_expect(300, 200, 40);
        model_advance(1'b0);
    endtask

    task automatic test_off_map();
        bit want_rd [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        sweep(140, 419, 1'b0, 1'b0, 0);
        compute_expect(140, 419, 0);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (obs_rd[2 + 2 * k] !== want_rd[k]) begin
                n_err++; $display("FAIL off_map_rd%0d got %b want %b", k, obs_rd[2 + 2 * k], want_rd[k]);
            end
            n_vec++;
            if (obs_poll[10][k] !== exp_code[k] || (!want_rd[k] && obs_poll[10][k] !== 3'b111)) begin
                n_err++; $display("FAIL off_map_poll%0d got %0d want %0d", k, obs_poll[10][k], exp_code[k]);
            end
        end
        n_vec++;
        if (obs_addr[4] !== obs_addr[3] || obs_addr[6] !== obs_addr[3]) begin
            n_err++; $display("FAIL off_map_hold_addr got %0d/%0d want %0d", obs_addr[4], obs_addr[6], obs_addr[3]);
        end
        model_advance(1'b0);
    endtask

    task automatic test_hold_ignore();
        int pulses = 0;
        int x = $urandom_range(200, 450), y = $urandom_range(100, 380);
        sweep(x, y, 1'b0, 1'b1, 0);
        compute_expect(x, y, lat_scroll);
        for (int c = 1; c <= 20; c++) begin
            pulses += int'(obs_pv[c]);
            for (int k = 0; k < 4; k++) begin
                n_vec++;
                if (obs_poll[c][k] !== ((c < 10) ? m_poll[k] : exp_code[k])) begin
                    n_err++; $display("FAIL hold_poll c=%0d k=%0d got %0d want %0d", c, k, obs_poll[c][k], (c < 10) ? m_poll[k] : exp_code[k]);
                end
            end
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL hold_pulses got %0d want 1", pulses); end
        model_advance(1'b0);
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        sweep(320, 240, 1'b0, 1'b0, 0);
        compute_expect(320, 240, lat_scroll);
        model_advance(1'b0);
        sweep(260, 300, 1'b1, 1'b0, 5);
        for (int c = 1; c <= 20; c++) pulses += int'(obs_pv[c]);
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL rst_mid_pulses got %0d want 0", pulses); end
        n_vec++; if (obs_scroll[5] !== 13'(lat_scroll)) begin n_err++; $display("FAIL rst_mid_scroll_pre got %0d want %0d", obs_scroll[5], lat_scroll); end
        n_vec++; if (obs_scroll[6] !== 13'd0) begin n_err++; $display("FAIL rst_mid_scroll got %0d want 0", obs_scroll[6]); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (obs_poll[6][k] !== 3'd0 || obs_poll[20][k] !== 3'd0) begin
                n_err++; $display("FAIL rst_mid_poll%0d got %0d/%0d want 0", k, obs_poll[6][k], obs_poll[20][k]);
            end
        end
        model_advance(1'b1);
        sweep(300, 200, 1'b0, 1'b0, 0);
        compute_expect(300, 200, lat_scroll);
        n_vec++; if (obs_pv[10] !== 1'b1) begin n_err++; $display("FAIL rst_mid_next_valid got %b want 1", obs_pv[10]); end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (obs_poll[10][k] !== exp_code[k]) begin
                n_err++; $display("FAIL rst_mid_next_poll%0d got %0d want %0d", k, obs_poll[10][k], exp_code[k]);
            end
        end
        model_advance(1'b0);
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 1; i <= 119; i++) begin
            Shift = 1'b1;
            tick();
            Shift = 1'b0;
            scroll_m = (scroll_m + SHIFT_PX > SCROLL_MAX) ? SCROLL_MAX : scroll_m + SHIFT_PX;
            n_vec++;
            if (scroll_px !== 13'(scroll_m)) begin
                n_err++; $display("FAIL saturation step=%0d got %0d want %0d", i, scroll_px, scroll_m);
            end
        end
        tick();
        n_vec++; if (scroll_px !== 13'd4720) begin n_err++; $display("FAIL saturation_hold got %0d want 4720", scroll_px); end
    endtask

    task automatic test_random_frames(input int n);
        for (int f = 0; f < n; f++) begin
            int x = $urandom_range(90, 560), y = $urandom_range(10, 470);
            int running = m_last_addr;
            bit sh = ($urandom_range(0, 2) == 0);
            sweep(x, y, sh, 1'b0, 0);
            compute_expect(x, y, lat_scroll);
            for (int c = 1; c <= 12; c++) begin
                bit want_rd = (c >= 2 && c <= 8 && c % 2 == 0) && !exp_off[(c - 2) / 2];
                if (want_rd) running = exp_addr[(c - 2) / 2];
                n_vec++;
                if (obs_rd[c] !== want_rd || obs_addr[c] !== 13'(running)) begin
                    n_err++; $display("FAIL rand_bus f=%0d c=%0d rd=%b addr=%0d want rd=%b addr=%0d", f, c, obs_rd[c], obs_addr[c], want_rd, running);
                end
                n_vec++;
                if (obs_pv[c] !== (c == 10) || obs_scroll[c] !== 13'(scroll_m)) begin
                    n_err++; $display("FAIL rand_valid f=%0d c=%0d pv=%b scroll=%0d want pv=%b scroll=%0d", f, c, obs_pv[c], obs_scroll[c], c == 10, scroll_m);
                end
                for (int k = 0; k < 4; k++) begin
                    n_vec++;
                    if (obs_poll[c][k] !== ((c < 10) ? m_poll[k] : exp_code[k])) begin
                        n_err++; $display("FAIL rand_poll f=%0d c=%0d k=%0d got %0d want %0d", f, c, k, obs_poll[c][k], (c < 10) ? m_poll[k] : exp_code[k]);
                    end
                end
            end
            model_advance(1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 3'($urandom);
        test_reset();
        test_map_read();
        test_scroll();
        test_off_map();
        test_hold_ignore();
        test_reset_mid();
        test_random_frames(20);
        test_saturation();
        test_random_frames(20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1);
    end

endmodule
